// File: rtl/seg_adder_pkg.sv
// seg_adder_pkg: shared FSM encoding and segment-count helpers for seg_adder.
package seg_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of SEG_W-bit slices in a WIDTH-bit operand.
   function automatic int seg_count(input int width, input int seg_w);
      return width / seg_w;
   endfunction

   // Width of the slice index; at least one bit so the register always exists.
   function automatic int seg_idx_w(input int width, input int seg_w);
      int n;
      n = width / seg_w;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_add_unit.sv
// seg_add_unit: combinational W-bit ripple-carry adder slice.
module seg_add_unit #(
   parameter int W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   // Ripple the carry bit by bit from the LSB.
   always_comb begin
      logic c;
      s = '0;
      c = ci;
      for (int i = 0; i < W; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      co = c;
   end

endmodule

// File: rtl/seg_adder.sv
// seg_adder: multi-cycle adder processing one SEG_W-bit slice per clock,
// LSB slice first. Optional subtract mode under macro SEG_ADDER_SUB_EN
// adds a 'sub' port; subtraction is done as a + ~b + 1 by inverting b and
// forcing the carry-in at capture time, so the datapath is unchanged.
module seg_adder
   import seg_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEG_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG  = seg_count(WIDTH, SEG_W);
   localparam int IDX_W = seg_idx_w(WIDTH, SEG_W);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [WIDTH-1:0]   a_q, b_q, acc, acc_nxt;
   logic               c_q;
   logic [SEG_W-1:0]   x_sl, y_sl, s_sl;
   logic               co_sl;
   logic               op_sub;
   logic               accept;
   logic               last;

`ifdef SEG_ADDER_SUB_EN
   assign op_sub = sub;
`else
   assign op_sub = 1'b0;
`endif

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (idx == IDX_W'(NSEG - 1));
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   assign x_sl = a_q[int'(idx)*SEG_W +: SEG_W];
   assign y_sl = b_q[int'(idx)*SEG_W +: SEG_W];

   seg_add_unit #(.W(SEG_W)) u_unit (
      .x  (x_sl),
      .y  (y_sl),
      .ci (c_q),
      .s  (s_sl),
      .co (co_sl)
   );

   // Accumulated result with the current slice merged in.
   always_comb begin
      acc_nxt = acc;
      acc_nxt[int'(idx)*SEG_W +: SEG_W] = s_sl;
   end

   // Next-state logic: start is only honoured in IDLE and DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, per-slice accumulation and result publication on the
   // edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= 1'b0;
         idx  <= '0;
         acc  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (accept) begin
         a_q <= a;
         b_q <= op_sub ? ~b : b;
         c_q <= op_sub ? 1'b1 : cin;
         idx <= '0;
         acc <= '0;
      end else if (state == RUN) begin
         acc <= acc_nxt;
         c_q <= co_sl;
         idx <= last ? '0 : idx + IDX_W'(1);
         if (last) begin
            sum  <= acc_nxt;
            cout <= co_sl;
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end

endmodule
